// File: rtl/ram_arb_pkg.sv
// Shared types for the two-requester RAM port arbiter: FSM state
// encoding and the in-flight read entry carried down the latency pipe.
package ram_arb_pkg;

  // Top-level FSM: INIT clears the RAM, RUN arbitrates requesters.
  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } arb_state_e;

  // One outstanding read: valid flag plus the requester it belongs to.
  typedef struct packed {
    logic valid;
    logic id;
  } inflight_t;

  // Requester identifiers as carried in inflight_t.id.
  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;

endpackage

// File: rtl/ram_arb_rd_tracker.sv
// Read-return tracker: a RAM_LATENCY-deep shift register of {valid, id}.
// An entry pushed in cycle T appears on valid_out/id_out in cycle
// T+RAM_LATENCY, one entry per cycle, so back-to-back reads are fine.
module ram_arb_rd_tracker
  import ram_arb_pkg::*;
#(
  parameter int RAM_LATENCY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic id,
  output logic valid_out,
  output logic id_out
);

  inflight_t pipe_q [RAM_LATENCY];

  // Shift entries one stage per cycle; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RAM_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= '{valid: push, id: id};
      for (int i = 1; i < RAM_LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign valid_out = pipe_q[RAM_LATENCY-1].valid;
  assign id_out    = pipe_q[RAM_LATENCY-1].id;

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter in front of a single RAM port (port A).
// After reset it sweeps the whole RAM writing zeros (INIT), then grants
// one requester per cycle with round-robin on conflict (RUN). Read data
// is routed back to the issuing requester RAM_LATENCY cycles later.
// Optional macro RAM_ARB_STATS_EN compiles the conflict counter; when it
// is undefined stat_conflicts is tied to zero.
//
// Handshake: rN_req is a request held stable (with we/addr/wdata) until
// rN_gnt; rN_gnt is combinational and means "accepted this cycle". There
// is no back-pressure on read returns: rN_rvalid is a one-cycle pulse.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int RAM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  // requester 0
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  // requester 1
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  // RAM port A
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_q,
  // status
  output logic              init_done,
  output logic [15:0]       stat_conflicts,
  output logic              dbg_state
);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;
  logic              init_done_q, init_done_d;
  logic              last_winner_q, last_winner_d;
  logic [ADDR_W-1:0] addr_hold_q;
  logic [DATA_W-1:0] data_hold_q;

  logic              gnt0, gnt1;
  logic              rd_push, rd_push_id;
  logic [ADDR_W-1:0] ram_addr_c;
  logic [DATA_W-1:0] ram_data_c;
  logic              ram_wren_c;
  logic              trk_valid, trk_id;

  // Grant logic: single request wins outright, conflict goes to the
  // requester that did not win last; nothing is granted during INIT.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == RUN) begin
      if (r0_req && r1_req) begin
        if (last_winner_q == REQ_ID1) gnt0 = 1'b1;
        else                          gnt1 = 1'b1;
      end else if (r0_req) begin
        gnt0 = 1'b1;
      end else if (r1_req) begin
        gnt1 = 1'b1;
      end
    end
  end

  // RAM port mux: clear sweep in INIT, granted requester in RUN, and
  // otherwise hold the last address/data with the write disabled.
  always_comb begin
    ram_addr_c = addr_hold_q;
    ram_data_c = data_hold_q;
    ram_wren_c = 1'b0;
    if (state_q == INIT) begin
      ram_addr_c = sweep_q;
      ram_data_c = '0;
      ram_wren_c = 1'b1;
    end else if (gnt0) begin
      ram_addr_c = r0_addr;
      ram_data_c = r0_wdata;
      ram_wren_c = r0_we;
    end else if (gnt1) begin
      ram_addr_c = r1_addr;
      ram_data_c = r1_wdata;
      ram_wren_c = r1_we;
    end
  end

  // Reads enter the tracker on the grant cycle, tagged with the winner.
  always_comb begin
    rd_push    = (gnt0 && !r0_we) || (gnt1 && !r1_we);
    rd_push_id = gnt1 ? REQ_ID1 : REQ_ID0;
  end

  // FSM next state, sweep counter and round-robin bookkeeping.
  always_comb begin
    state_d       = state_q;
    sweep_d       = sweep_q;
    init_done_d   = init_done_q;
    last_winner_d = last_winner_q;
    case (state_q)
      INIT: begin
        sweep_d = sweep_q + ADDR_W'(1);
        if (&sweep_q) begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end
      end
      RUN: begin
        if (gnt0)      last_winner_d = REQ_ID0;
        else if (gnt1) last_winner_d = REQ_ID1;
      end
      default: state_d = INIT;
    endcase
  end

  // State registers; reset restarts the sweep and the round-robin.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= INIT;
      sweep_q       <= '0;
      init_done_q   <= 1'b0;
      last_winner_q <= REQ_ID1;
    end else begin
      state_q       <= state_d;
      sweep_q       <= sweep_d;
      init_done_q   <= init_done_d;
      last_winner_q <= last_winner_d;
    end
  end

  // Remember what was last presented to the RAM so idle cycles hold it.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_hold_q <= '0;
      data_hold_q <= '0;
    end else begin
      addr_hold_q <= ram_addr_c;
      data_hold_q <= ram_data_c;
    end
  end

  ram_arb_rd_tracker #(
    .RAM_LATENCY (RAM_LATENCY)
  ) u_rd_tracker (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_push),
    .id        (rd_push_id),
    .valid_out (trk_valid),
    .id_out    (trk_id)
  );

`ifdef RAM_ARB_STATS_EN
  logic [15:0] conflicts_q;

  // Count RUN cycles with both requests present, saturating at 0xFFFF.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflicts_q <= '0;
    end else if ((state_q == RUN) && r0_req && r1_req && (conflicts_q != 16'hFFFF)) begin
      conflicts_q <= conflicts_q + 16'd1;
    end
  end

  assign stat_conflicts = conflicts_q;
`else
  assign stat_conflicts = '0;
`endif

  assign r0_gnt    = gnt0;
  assign r1_gnt    = gnt1;
  assign r0_rvalid = trk_valid && (trk_id == REQ_ID0);
  assign r1_rvalid = trk_valid && (trk_id == REQ_ID1);
  assign r0_rdata  = r0_rvalid ? ram_q : '0;
  assign r1_rdata  = r1_rvalid ? ram_q : '0;

  assign ram_addr  = ram_addr_c;
  assign ram_data  = ram_data_c;
  assign ram_wren  = ram_wren_c;
  assign ram_clken = 1'b1;
  assign init_done = init_done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with ADDR_W=4, RAM_LATENCY=2 and
// a behavioural port-A RAM (registered address and output, new-data on
// same-address write). Expected values are hand-computed constants.
module tb_ram_port_arbiter;

  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          r0_req, r0_we, r1_req, r1_we;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wdata, r1_wdata;
  logic          r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_wren, ram_clken;
  logic [DW-1:0] ram_data, ram_q;
  logic          init_done, dbg_state;
  logic [15:0]   stat_conflicts;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_stat;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- RAM model ----------------
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] q1, q2;
  always @(posedge clk) begin
    if (ram_clken) begin
      if (ram_wren) mem[ram_addr] <= ram_data;
      q1 <= ram_wren ? ram_data : mem[ram_addr];
      q2 <= q1;
    end
  end
  assign ram_q = q2;

  ram_port_arbiter #(
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .RAM_LATENCY (LAT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .r0_req         (r0_req),
    .r0_we          (r0_we),
    .r0_addr        (r0_addr),
    .r0_wdata       (r0_wdata),
    .r0_gnt         (r0_gnt),
    .r0_rvalid      (r0_rvalid),
    .r0_rdata       (r0_rdata),
    .r1_req         (r1_req),
    .r1_we          (r1_we),
    .r1_addr        (r1_addr),
    .r1_wdata       (r1_wdata),
    .r1_gnt         (r1_gnt),
    .r1_rvalid      (r1_rvalid),
    .r1_rdata       (r1_rdata),
    .ram_addr       (ram_addr),
    .ram_wren       (ram_wren),
    .ram_data       (ram_data),
    .ram_clken      (ram_clken),
    .ram_q          (ram_q),
    .init_done      (init_done),
    .stat_conflicts (stat_conflicts),
    .dbg_state      (dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    r0_req = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
    r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
  endtask

  task automatic drive0(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    r0_req = 1'b1; r0_we = we; r0_addr = a; r0_wdata = d;
  endtask

  task automatic drive1(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    r1_req = 1'b1; r1_we = we; r1_addr = a; r1_wdata = d;
  endtask

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state, then the clear sweep over addresses 0..15.
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_stat", {16'd0, stat_conflicts}, 32'd0);
    chk("rst_state", {31'd0, dbg_state}, 32'd0);
    chk("rst_r0_rvalid", {31'd0, r0_rvalid}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("sweep_wren_%0d", i), {31'd0, ram_wren}, 32'd1);
      chk($sformatf("sweep_addr_%0d", i), {28'd0, ram_addr}, i);
      chk($sformatf("sweep_data_%0d", i), ram_data, 32'd0);
      chk($sformatf("sweep_done_%0d", i), {31'd0, init_done}, 32'd0);
      tick();
    end
    chk("init_done_16", {31'd0, init_done}, 32'd1);
    chk("state_run_16", {31'd0, dbg_state}, 32'd1);
    chk("idle_wren_16", {31'd0, ram_wren}, 32'd0);

    // r1 reads address 5 (cleared): data 0, two cycles after the grant.
    drive1(1'b0, 4'd5, '0); #1;
    chk("rd5_gnt1", {31'd0, r1_gnt}, 32'd1);
    chk("rd5_addr", {28'd0, ram_addr}, 32'd5);
    chk("rd5_wren", {31'd0, ram_wren}, 32'd0);
    tick(); idle(); #1;
    chk("rd5_early", {31'd0, r1_rvalid}, 32'd0);
    tick();
    chk("rd5_rvalid", {31'd0, r1_rvalid}, 32'd1);
    chk("rd5_rdata", r1_rdata, 32'd0);
    chk("rd5_r0_quiet", {31'd0, r0_rvalid}, 32'd0);
    tick();
    chk("rd5_pulse_end", {31'd0, r1_rvalid}, 32'd0);

    // r0 writes 0xA5A5A5A5 to address 3, then reads it back.
    drive0(1'b1, 4'd3, 32'hA5A5_A5A5); #1;
    chk("wr3_gnt0", {31'd0, r0_gnt}, 32'd1);
    chk("wr3_wren", {31'd0, ram_wren}, 32'd1);
    chk("wr3_data", ram_data, 32'hA5A5_A5A5);
    tick();
    drive0(1'b0, 4'd3, '0); #1;
    chk("rd3_gnt0", {31'd0, r0_gnt}, 32'd1);
    chk("wr3_no_rvalid", {31'd0, r0_rvalid | r1_rvalid}, 32'd0);
    tick(); idle(); #1;
    chk("rd3_early", {31'd0, r0_rvalid}, 32'd0);
    chk("hold_addr", {28'd0, ram_addr}, 32'd3);
    chk("hold_wren", {31'd0, ram_wren}, 32'd0);
    tick();
    chk("rd3_rvalid", {31'd0, r0_rvalid}, 32'd1);
    chk("rd3_rdata", r0_rdata, 32'hA5A5_A5A5);
    chk("rd3_r1_quiet", {31'd0, r1_rvalid}, 32'd0);
    tick();
    chk("rd3_pulse_end", {31'd0, r0_rvalid}, 32'd0);
    chk("rd3_rdata_zero", r0_rdata, 32'd0);

    // Preload addresses 1 and 2 with distinct data.
    drive1(1'b1, 4'd1, 32'h1111_1111); tick(); idle();
    drive0(1'b1, 4'd2, 32'h2222_2222); tick(); idle();

    // Back-to-back reads r0@1, r1@2, r0@3 on consecutive cycles.
    drive0(1'b0, 4'd1, '0); #1;
    chk("b2b_g0", {31'd0, r0_gnt}, 32'd1);
    tick(); idle();
    drive1(1'b0, 4'd2, '0); #1;
    chk("b2b_g1", {31'd0, r1_gnt}, 32'd1);
    tick(); idle();
    drive0(1'b0, 4'd3, '0); #1;
    chk("b2b_g2", {31'd0, r0_gnt}, 32'd1);
    chk("b2b_ret0_v0", {31'd0, r0_rvalid}, 32'd1);
    chk("b2b_ret0_v1", {31'd0, r1_rvalid}, 32'd0);
    chk("b2b_ret0_d", r0_rdata, 32'h1111_1111);
    tick(); idle(); #1;
    chk("b2b_ret1_v0", {31'd0, r0_rvalid}, 32'd0);
    chk("b2b_ret1_v1", {31'd0, r1_rvalid}, 32'd1);
    chk("b2b_ret1_d", r1_rdata, 32'h2222_2222);
    tick();
    chk("b2b_ret2_v0", {31'd0, r0_rvalid}, 32'd1);
    chk("b2b_ret2_v1", {31'd0, r1_rvalid}, 32'd0);
    chk("b2b_ret2_d", r0_rdata, 32'hA5A5_A5A5);
    tick();
    chk("b2b_drain", {31'd0, r0_rvalid | r1_rvalid}, 32'd0);

    // r1 wins a single write so r0 is next in line for a conflict.
    drive1(1'b1, 4'd9, 32'h0000_0009); #1;
    chk("prep_g1", {31'd0, r1_gnt}, 32'd1);
    tick(); idle();

    // Six cycles of conflicting reads: r0@1 vs r1@2, alternating grants.
    for (int k = 0; k < 6; k++) begin
      drive0(1'b0, 4'd1, '0);
      drive1(1'b0, 4'd2, '0);
      #1;
      chk($sformatf("conf_g0_%0d", k), {31'd0, r0_gnt}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("conf_g1_%0d", k), {31'd0, r1_gnt}, (k % 2 == 1) ? 32'd1 : 32'd0);
      if (k >= 2) begin
        chk($sformatf("conf_rv0_%0d", k), {31'd0, r0_rvalid}, (k % 2 == 0) ? 32'd1 : 32'd0);
        chk($sformatf("conf_rv1_%0d", k), {31'd0, r1_rvalid}, (k % 2 == 1) ? 32'd1 : 32'd0);
        chk($sformatf("conf_rd_%0d", k), r0_rdata | r1_rdata,
            (k % 2 == 0) ? 32'h1111_1111 : 32'h2222_2222);
      end
      tick();
    end
    idle(); #1;
`ifdef RAM_ARB_STATS_EN
    exp_stat = 16'd6;
`else
    exp_stat = 16'd0;
`endif
    chk("conf_stat", {16'd0, stat_conflicts}, {16'd0, exp_stat});
    chk("conf_tail_rv0", {31'd0, r0_rvalid}, 32'd1);
    chk("conf_tail_d0", r0_rdata, 32'h1111_1111);
    tick();
    chk("conf_tail_rv1", {31'd0, r1_rvalid}, 32'd1);
    chk("conf_tail_d1", r1_rdata, 32'h2222_2222);
    tick();

    // Reset one cycle after a read grant: in-flight read is dropped.
    drive0(1'b0, 4'd3, '0); #1;
    chk("rr_gnt0", {31'd0, r0_gnt}, 32'd1);
    tick(); idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rr_state", {31'd0, dbg_state}, 32'd0);
    chk("rr_init_done", {31'd0, init_done}, 32'd0);
    chk("rr_stat", {16'd0, stat_conflicts}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      drive0(1'b0, 4'd3, '0);
      drive1(1'b1, 4'd7, 32'hDEAD_BEEF);
      #1;
      chk($sformatf("rr_gnt0_%0d", i), {31'd0, r0_gnt}, 32'd0);
      chk($sformatf("rr_gnt1_%0d", i), {31'd0, r1_gnt}, 32'd0);
      chk($sformatf("rr_rvalid_%0d", i), {31'd0, r0_rvalid | r1_rvalid}, 32'd0);
      chk($sformatf("rr_addr_%0d", i), {28'd0, ram_addr}, i);
      chk($sformatf("rr_data_%0d", i), ram_data, 32'd0);
      tick();
    end
    idle(); #1;
    chk("rr_done", {31'd0, init_done}, 32'd1);
    chk("rr_stat_init", {16'd0, stat_conflicts}, 32'd0);

    // Address 3 was cleared by the new sweep.
    drive0(1'b0, 4'd3, '0); #1;
    chk("rr_rd_gnt", {31'd0, r0_gnt}, 32'd1);
    tick(); idle();
    tick();
    chk("rr_rd_rvalid", {31'd0, r0_rvalid}, 32'd1);
    chk("rr_rd_data", r0_rdata, 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net against a hung sequence.
  initial begin
    #100000;
    $display("FAIL timeout: sequence did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, RAM word width.
REQ-002 SHALL have parameter ADDR_W, default 8, RAM address width; depth is 2^ADDR_W.
REQ-003 SHALL have parameter RAM_LATENCY, default 2, cycles from the address-sampling edge to valid ram_q (range 1..8).
REQ-004 SHALL have port clk  input  1  clock. One clock; reset is synchronous and active-high.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have ports rN_req  input  1  requester N (N=0,1) access request.
REQ-007 SHALL have ports rN_we  input  1  request is a write (1) or a read (0).
REQ-008 SHALL have ports rN_addr  input  ADDR_W  request address.
REQ-009 SHALL have ports rN_wdata  input  DATA_W  write data.
REQ-010 SHALL have ports rN_gnt  output  1  request accepted this cycle.
REQ-011 SHALL have ports rN_rvalid  output  1  read data valid for requester N.
REQ-012 SHALL have ports rN_rdata  output  DATA_W  read data; 0 when rN_rvalid=0.
REQ-013 SHALL have port ram_addr  output  ADDR_W  to RAM port A address.
REQ-014 SHALL have port ram_wren  output  1  to RAM port A write enable.
REQ-015 SHALL have port ram_data  output  DATA_W  to RAM port A write data.
REQ-016 SHALL have port ram_clken  output  1  RAM clock enable; constant 1.
REQ-017 SHALL have port ram_q  input  DATA_W  from RAM port A read data.
REQ-018 SHALL have port init_done  output  1  RAM clear sweep complete.
REQ-019 SHALL have port stat_conflicts  output  16  count of cycles with both requests present.

Function
REQ-020 SHALL implement FSM states INIT and RUN; rst forces INIT.
REQ-021 In INIT, SHALL drive ram_wren=1, ram_data=0, and ram_addr=sweep counter; the counter starts at 0 and increments each cycle.
REQ-022 SHALL move INIT->RUN on the cycle after writing address 2^ADDR_W-1, with init_done=1 registered from that cycle.
REQ-023 In INIT, SHALL hold r0_gnt=r1_gnt=0; requests are ignored, not queued.
REQ-024 In RUN, SHALL grant at most one requester per cycle; rN_gnt is combinational from rN_req and the arbitration state.
REQ-025 Single request: SHALL grant it in the same cycle.
REQ-026 Both requests: SHALL grant the requester not granted last (round-robin); last_winner resets to 1, so r0 wins the first conflict.
REQ-027 SHALL drive ram_addr/ram_wren/ram_data combinationally from the granted requester; with no grant, ram_wren=0 and ram_addr/ram_data hold their previous values.
REQ-028 Requesters SHALL hold req/we/addr/wdata stable until gnt; the arbiter does not check this.
REQ-029 A granted read in cycle T SHALL produce rN_rvalid=1 for exactly one cycle, in cycle T+RAM_LATENCY, with rN_rdata=ram_q.
REQ-030 SHALL track in-flight reads in a RAM_LATENCY-deep shift register of {valid, id}; this supports back-to-back reads from either requester every cycle.
REQ-031 Writes SHALL produce no rvalid.
REQ-032 A same-address write-then-read SHALL return the new data; this relies on the port-A NEW_DATA behaviour.
REQ-033 stat_conflicts SHALL increment in RUN cycles where r0_req and r1_req are both 1, and saturate at 0xFFFF.

Reset
REQ-034 On rst=1 at a clk edge, SHALL set: state=INIT, sweep=0, init_done=0, last_winner=1, pipeline valid bits=0, stat_conflicts=0.
REQ-035 A reset mid-operation SHALL drop in-flight reads (no rvalid afterwards) and restart the sweep at address 0.

Configuration
REQ-036 Macro RAM_ARB_STATS_EN: when defined, SHALL compile the conflict counter.
REQ-037 When RAM_ARB_STATS_EN is undefined, stat_conflicts SHALL be tied to 0, with no counter logic; the port list is unchanged.

Structure
REQ-038 Shared package ram_arb_pkg SHALL hold the FSM state enum (INIT, RUN) and the in-flight entry struct {valid, id}.
REQ-039 The read-tracking shift register SHALL be sub-module ram_arb_rd_tracker (params RAM_LATENCY; inputs push, id; outputs valid_out, id_out).

Verification
REQ-040 Reset then idle, ADDR_W=4: ram_wren=1 for cycles 0..15 at addresses 0..15 with data 0; init_done=1 from cycle 16; a read of address 5 then returns 0.
REQ-041 r0 writes 0xA5A5A5A5 to address 3; next cycle r0 reads address 3: r0_rvalid=1 exactly RAM_LATENCY=2 cycles after the read grant, r0_rdata=0xA5A5A5A5, r1_rvalid=0.
REQ-042 r0 and r1 request every cycle for 6 cycles: grants alternate r0,r1,r0,r1,r0,r1, and stat_conflicts=6 with RAM_ARB_STATS_EN (0 without).
REQ-043 Back-to-back reads r0@1, r1@2, r0@3 in consecutive cycles: rvalids follow the same order on consecutive cycles, with no gaps or misrouting.
REQ-044 rst asserted one cycle after a read grant: no rvalid follows, the sweep restarts at 0, and requests during INIT see gnt=0.
